// File: rtl/run_ctrl_pkg.sv
// Shared types for the run controller: FSM encoding
// and default statistics counter width.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      PAUSE = 2'b01,
      STEP  = 2'b10,
      HALT  = 2'b11
   } state_t;

   localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/btn_sync.sv
// Button synchronizer chain plus history flop;
// emits a one-cycle pulse on each synchronized rising edge.
module btn_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_pulse
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync[0] <= i_btn;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/run_ctrl.sv
// Run/pause/step/halt controller for the pipeline,
// with cycle and branch statistics counters.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int CNT_W        = CNT_W_DEF,
   parameter int START_PAUSED = 0,
   parameter int SYNC_STAGES  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pause_btn,
   input  logic             step_btn,
   input  logic             halt_req,
   input  logic             load_use_stall,
   input  logic             branch_taken,
   input  logic             uncond_jump,
   input  logic             clr_stats,
   output logic             pc_enable,
   output logic             pipe_enable,
   output logic [1:0]       run_state,
   output logic             halted,
   output logic [CNT_W-1:0] total_cycles,
   output logic [CNT_W-1:0] condi_branch_num,
   output logic [CNT_W-1:0] uncondi_branch_num
);

   localparam state_t           RST_STATE = (START_PAUSED != 0) ? PAUSE : RUN;
   localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_next;
   logic             w_pause;
   logic             w_step;
   logic             w_active;
   logic [CNT_W-1:0] r_total;
   logic [CNT_W-1:0] r_condi;
   logic [CNT_W-1:0] r_uncondi;

   btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pause_sync (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (pause_btn),
      .o_pulse (w_pause)
   );

   btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (step_btn),
      .o_pulse (w_step)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= RST_STATE;
      end else begin
         r_state <= w_next;
      end
   end

   // Edges arriving in STEP or HALT fall through and are lost.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         RUN: begin
            if (halt_req)     w_next = HALT;
            else if (w_pause) w_next = PAUSE;
         end
         PAUSE: begin
            if (w_pause)     w_next = RUN;
            else if (w_step) w_next = STEP;
         end
         STEP: begin
            w_next = halt_req ? HALT : PAUSE;
         end
         HALT: begin
            w_next = HALT;
         end
      endcase
   end

   assign w_active = (r_state == RUN) || (r_state == STEP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_total   <= '0;
         r_condi   <= '0;
         r_uncondi <= '0;
      end else if (clr_stats) begin
         r_total   <= '0;
         r_condi   <= '0;
         r_uncondi <= '0;
      end else if (w_active) begin
         r_total <= r_total + ONE;
         if (branch_taken) r_condi   <= r_condi + ONE;
         if (uncond_jump)  r_uncondi <= r_uncondi + ONE;
      end
   end

   assign pipe_enable        = w_active;
   assign pc_enable          = w_active & ~load_use_stall;
   assign run_state          = r_state;
   assign halted             = (r_state == HALT);
   assign total_cycles       = r_total;
   assign condi_branch_num   = r_condi;
   assign uncondi_branch_num = r_uncondi;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: default instance plus
// a 4-bit counter instance for wrap and clear priority.
module tb_run_ctrl;
   import run_ctrl_pkg::*;

   logic        clk;
   logic        rst;
   logic        pause_btn;
   logic        step_btn;
   logic        halt_req;
   logic        load_use_stall;
   logic        branch_taken;
   logic        uncond_jump;
   logic        clr_stats;
   logic        pc_enable;
   logic        pipe_enable;
   logic [1:0]  run_state;
   logic        halted;
   logic [31:0] total_cycles;
   logic [31:0] condi_branch_num;
   logic [31:0] uncondi_branch_num;

   logic        rst4;
   logic        clr4;
   logic        pc4;
   logic        pipe4;
   logic [1:0]  state4;
   logic        halted4;
   logic [3:0]  total4;
   logic [3:0]  condi4;
   logic [3:0]  uncondi4;

   int          n_chk;
   int          n_err;
   logic [31:0] t0;
   int          cnt;

   run_ctrl dut (
      .clk                (clk),
      .rst                (rst),
      .pause_btn          (pause_btn),
      .step_btn           (step_btn),
      .halt_req           (halt_req),
      .load_use_stall     (load_use_stall),
      .branch_taken       (branch_taken),
      .uncond_jump        (uncond_jump),
      .clr_stats          (clr_stats),
      .pc_enable          (pc_enable),
      .pipe_enable        (pipe_enable),
      .run_state          (run_state),
      .halted             (halted),
      .total_cycles       (total_cycles),
      .condi_branch_num   (condi_branch_num),
      .uncondi_branch_num (uncondi_branch_num)
   );

   run_ctrl #(.CNT_W(4)) dut4 (
      .clk                (clk),
      .rst                (rst4),
      .pause_btn          (1'b0),
      .step_btn           (1'b0),
      .halt_req           (1'b0),
      .load_use_stall     (1'b0),
      .branch_taken       (1'b0),
      .uncond_jump        (1'b0),
      .clr_stats          (clr4),
      .pc_enable          (pc4),
      .pipe_enable        (pipe4),
      .run_state          (state4),
      .halted             (halted4),
      .total_cycles       (total4),
      .condi_branch_num   (condi4),
      .uncondi_branch_num (uncondi4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b0;
      rst4 = 1'b0;
      clr4 = 1'b0;
      pause_btn = 1'b0;
      step_btn = 1'b0;
      halt_req = 1'b0;
      load_use_stall = 1'b0;
      branch_taken = 1'b0;
      uncond_jump = 1'b0;
      clr_stats = 1'b0;
      repeat (3) tick();
      check("rst_state", 64'(run_state), 64'(RUN));
      check("rst_total", 64'(total_cycles), 64'(0));
      check("rst_halted", 64'(halted), 64'(0));
      check("rst_pipe", 64'(pipe_enable), 64'(1));
      check("rst_pc", 64'(pc_enable), 64'(1));

      rst = 1'b1;
      cnt = 0;
      repeat (100) begin
         if (!pc_enable) cnt++;
         tick();
      end
      check("run100_total", 64'(total_cycles), 64'(100));
      check("run100_pc_low", 64'(cnt), 64'(0));
      check("run100_state", 64'(run_state), 64'(RUN));

      t0 = total_cycles;
      pause_btn = 1'b1;
      tick();
      check("pause_k", 64'(run_state), 64'(RUN));
      tick();
      check("pause_k1", 64'(run_state), 64'(RUN));
      tick();
      check("pause_k2", 64'(run_state), 64'(PAUSE));
      check("pause_total", 64'(total_cycles), 64'(t0 + 3));
      check("pause_pc", 64'(pc_enable), 64'(0));
      check("pause_pipe", 64'(pipe_enable), 64'(0));
      pause_btn = 1'b0;
      t0 = total_cycles;
      repeat (5) tick();
      check("pause_frozen", 64'(total_cycles), 64'(t0));
      pause_btn = 1'b1;
      repeat (3) tick();
      check("resume", 64'(run_state), 64'(RUN));
      pause_btn = 1'b0;
      repeat (3) tick();

      pause_btn = 1'b1;
      repeat (3) tick();
      pause_btn = 1'b0;
      repeat (4) tick();
      check("pause_again", 64'(run_state), 64'(PAUSE));
      t0 = total_cycles;
      for (int s = 0; s < 3; s++) begin
         step_btn = 1'b1;
         cnt = 0;
         for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 0) step_btn = 1'b0;
            if (pipe_enable) cnt++;
            if (s == 0 && c == 2)
               check("step_state", 64'(run_state), 64'(STEP));
            if (s == 0 && c == 3)
               check("step_back", 64'(run_state), 64'(PAUSE));
         end
         check("step_pulse", 64'(cnt), 64'(1));
      end
      check("step_total", 64'(total_cycles), 64'(t0 + 3));

      pause_btn = 1'b1;
      repeat (3) tick();
      pause_btn = 1'b0;
      check("run_again", 64'(run_state), 64'(RUN));
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      check("clr_total", 64'(total_cycles), 64'(0));
      check("clr_condi", 64'(condi_branch_num), 64'(0));
      branch_taken = 1'b1;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         load_use_stall = (i == 1 || i == 3);
         #1;
         if (!pc_enable) cnt++;
         check("stall_pc", 64'(pc_enable), 64'(!load_use_stall));
         tick();
      end
      branch_taken = 1'b0;
      load_use_stall = 1'b0;
      check("br_condi", 64'(condi_branch_num), 64'(5));
      check("br_pc_low", 64'(cnt), 64'(2));
      check("br_total", 64'(total_cycles), 64'(5));
      check("br_uncondi", 64'(uncondi_branch_num), 64'(0));
      branch_taken = 1'b1;
      uncond_jump = 1'b1;
      tick();
      branch_taken = 1'b0;
      uncond_jump = 1'b0;
      check("both_condi", 64'(condi_branch_num), 64'(6));
      check("both_uncondi", 64'(uncondi_branch_num), 64'(1));

      pause_btn = 1'b1;
      tick();
      tick();
      halt_req = 1'b1;
      t0 = total_cycles;
      tick();
      halt_req = 1'b0;
      pause_btn = 1'b0;
      check("halt_state", 64'(run_state), 64'(HALT));
      check("halt_flag", 64'(halted), 64'(1));
      check("halt_pipe", 64'(pipe_enable), 64'(0));
      check("halt_pc", 64'(pc_enable), 64'(0));
      check("halt_total", 64'(total_cycles), 64'(t0 + 1));
      t0 = total_cycles;
      pause_btn = 1'b1;
      step_btn = 1'b1;
      branch_taken = 1'b1;
      repeat (2) tick();
      pause_btn = 1'b0;
      step_btn = 1'b0;
      branch_taken = 1'b0;
      repeat (8) tick();
      check("halt_stuck", 64'(run_state), 64'(HALT));
      check("halt_frozen", 64'(total_cycles), 64'(t0));
      check("halt_condi", 64'(condi_branch_num), 64'(6));
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      check("halt_clr", 64'(total_cycles), 64'(0));
      rst = 1'b0;
      #1;
      check("rst_halt_state", 64'(run_state), 64'(RUN));
      check("rst_halt_flag", 64'(halted), 64'(0));
      check("rst_halt_pipe", 64'(pipe_enable), 64'(1));
      rst = 1'b1;
      tick();
      check("post_rst_total", 64'(total_cycles), 64'(1));

      pause_btn = 1'b1;
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      repeat (3) tick();
      check("held_btn", 64'(run_state), 64'(PAUSE));
      repeat (5) tick();
      check("held_once", 64'(run_state), 64'(PAUSE));
      pause_btn = 1'b0;

      rst4 = 1'b1;
      repeat (16) tick();
      check("w4_wrap", 64'(total4), 64'(0));
      tick();
      check("w4_17", 64'(total4), 64'(1));
      clr4 = 1'b1;
      tick();
      clr4 = 1'b0;
      check("w4_clr_prio", 64'(total4), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, the width of each statistics counter.
REQ-002 The block SHALL have parameter START_PAUSED, default 0, where 1 means leave reset in PAUSE and 0 means leave reset in RUN.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops per button input.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port pause_btn, input, 1 bit: asynchronous level that toggles RUN/PAUSE on each rising edge.
REQ-007 The block SHALL have port step_btn, input, 1 bit: asynchronous level whose rising edge requests a single step while paused.
REQ-008 The block SHALL have port halt_req, input, 1 bit: synchronous; decoded syscall exit from the datapath.
REQ-009 The block SHALL have port load_use_stall, input, 1 bit: synchronous; hazard stall from the pipeline.
REQ-010 The block SHALL have port branch_taken, input, 1 bit: synchronous; a conditional branch was taken this cycle.
REQ-011 The block SHALL have port uncond_jump, input, 1 bit: synchronous; a j/jal/jr was executed this cycle.
REQ-012 The block SHALL have port clr_stats, input, 1 bit: synchronous clear of all counters.
REQ-013 The block SHALL have port pc_enable, output, 1 bit: PC register write enable.
REQ-014 The block SHALL have port pipe_enable, output, 1 bit: global advance enable for the pipeline registers.
REQ-015 The block SHALL have port run_state, output, 2 bits: current FSM state.
REQ-016 The block SHALL have port halted, output, 1 bit: high when run_state is HALT.
REQ-017 The block SHALL have ports total_cycles, condi_branch_num and uncondi_branch_num, each output, CNT_W bits: statistics counters.

Function
REQ-018 The FSM SHALL have exactly the states RUN, PAUSE, STEP and HALT.
REQ-019 The block SHALL define "active" as run_state being RUN or STEP.
REQ-020 Each button SHALL pass through a SYNC_STAGES-flop synchronizer followed by one history flop; an edge pulse SHALL be generated as sync_out & ~history.
REQ-021 For a button first sampled high at edge k, the resulting state change SHALL become visible after edge k+SYNC_STAGES.
REQ-022 In RUN, halt_req=1 SHALL move to HALT; otherwise a pause edge SHALL move to PAUSE; otherwise the FSM SHALL stay in RUN.
REQ-023 In PAUSE, a pause edge SHALL move to RUN; otherwise a step edge SHALL move to STEP; halt_req SHALL be ignored.
REQ-024 STEP SHALL last exactly one cycle, then move to HALT if halt_req=1 and to PAUSE otherwise; all button edges seen during STEP SHALL be discarded.
REQ-025 HALT SHALL be exited only by reset; all inputs other than clr_stats SHALL be ignored in HALT.
REQ-026 pipe_enable SHALL be 1 exactly when active; it SHALL be combinational from run_state.
REQ-027 pc_enable SHALL equal active & ~load_use_stall; it SHALL be combinational.
REQ-028 total_cycles SHALL increment by 1 on every active cycle, including stalled cycles.
REQ-029 condi_branch_num SHALL increment on an active cycle when branch_taken=1; uncondi_branch_num SHALL increment on an active cycle when uncond_jump=1.
REQ-030 The cycle in which halt_req causes the transition to HALT SHALL be counted as active.
REQ-031 When branch_taken and uncond_jump are both 1 in the same active cycle, both counters SHALL increment.
REQ-032 Counters SHALL wrap modulo 2^CNT_W, so all-ones plus 1 gives 0.
REQ-033 clr_stats SHALL zero all counters on the next edge and SHALL take priority over any increment in the same cycle; it SHALL also act in PAUSE and HALT.

Reset
REQ-034 While rst=0, all flops SHALL clear immediately, including synchronizer and history flops.
REQ-035 While rst=0, all counters SHALL be 0.
REQ-036 While rst=0, run_state SHALL be PAUSE if START_PAUSED=1 and RUN otherwise.
REQ-037 While rst=0, halted SHALL be 0, and pipe_enable and pc_enable SHALL follow run_state.
REQ-038 A reset asserted mid-STEP or in HALT SHALL abandon the step or halt with no residual pulse.
REQ-039 A button held high through reset release SHALL produce one edge when sampled after release.

Structure
REQ-040 Package run_ctrl_pkg SHALL hold the state encoding (RUN=2'b00, PAUSE=2'b01, STEP=2'b10, HALT=2'b11) and the default CNT_W.
REQ-041 Sub-module btn_sync (synchronizer plus rising-edge pulse, parameter SYNC_STAGES) SHALL be instantiated once for pause_btn and once for step_btn.
REQ-042 Counters SHALL be inline in run_ctrl; no generic counter instance shall be required.

Verification
REQ-043 Scenario: reset, START_PAUSED=0, 100 cycles with no stall -> total_cycles=100, pc_enable=1 throughout, run_state=RUN.
REQ-044 Scenario: pause_btn pulse while in RUN -> PAUSE after edge k+2; pc_enable=0; total_cycles frozen; a second pause pulse -> RUN.
REQ-045 Scenario: in PAUSE, 3 step pulses spaced 10 cycles apart -> exactly 3 single-cycle pipe_enable pulses; total_cycles increases by exactly 3.
REQ-046 Scenario: in RUN, halt_req and a pause edge in the same cycle -> HALT; halted=1; further buttons have no effect; only reset returns to RUN.
REQ-047 Scenario: branch_taken=1 for 5 active cycles with load_use_stall=1 on 2 of them -> condi_branch_num=5; pc_enable low on exactly those 2 cycles.
REQ-048 Scenario: CNT_W=4, 17 active cycles -> total_cycles=1; clr_stats coincident with an increment -> counter reads 0.
